// File: rtl/mem_arb_pkg.sv
// Shared types for the IF/MEM memory port arbiter.
// State encoding, grant codes and default bus widths.
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_DM,
    RESP
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_IF   = 2'd1;
  localparam logic [1:0] GNT_DM   = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data accesses onto one single-ported memory.
// Data wins by default; a starvation counter forces a fetch grant.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int STARVE_MAX  = 4,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic [DATA_W-1:0] if_rdata_o,
  output logic              if_valid_o,
  output logic              if_stall_o,
  input  logic              dm_req_i,
  input  logic              dm_we_i,
  input  logic [ADDR_W-1:0] dm_addr_i,
  input  logic [DATA_W-1:0] dm_wdata_i,
  output logic [DATA_W-1:0] dm_rdata_o,
  output logic              dm_valid_o,
  output logic              dm_stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              timeout_o
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WAIT_LIM   = WW'(TIMEOUT_CYC);

  arb_state_t      r_state;
  logic [SW-1:0]   r_starve;
  logic [WW-1:0]   r_wait;
  logic [1:0]      w_gnt;

  assign if_stall_o = if_req_i & ~if_valid_o;
  assign dm_stall_o = dm_req_i & ~dm_valid_o;

  always_comb begin
    w_gnt = GNT_NONE;
    if (dm_req_i && !(if_req_i && r_starve == STARVE_LIM))
      w_gnt = GNT_DM;
    else if (if_req_i)
      w_gnt = GNT_IF;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_starve    <= '0;
      r_wait      <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      if_valid_o  <= 1'b0;
      dm_rdata_o  <= '0;
      dm_valid_o  <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          unique case (w_gnt)
            GNT_DM: begin
              mem_req_o   <= 1'b1;
              mem_we_o    <= dm_we_i;
              mem_addr_o  <= dm_addr_i;
              mem_wdata_o <= dm_wdata_i;
              r_state     <= BUSY_DM;
              if (if_req_i && r_starve != STARVE_LIM)
                r_starve <= r_starve + 1'b1;
            end
            GNT_IF: begin
              mem_req_o  <= 1'b1;
              mem_we_o   <= 1'b0;
              mem_addr_o <= if_addr_i;
              r_state    <= BUSY_IF;
              r_starve   <= '0;
            end
            default: ;
          endcase
        end
        BUSY_IF, BUSY_DM: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            r_wait    <= '0;
            r_state   <= RESP;
            if (r_state == BUSY_IF) begin
              if_rdata_o <= mem_rdata_i;
              if_valid_o <= 1'b1;
            end else begin
              dm_valid_o <= 1'b1;
              if (!mem_we_o)
                dm_rdata_o <= mem_rdata_i;
            end
          end else if (r_wait != WAIT_LIM) begin
            // Saturates so a hung memory cannot wrap the counter
            r_wait <= r_wait + 1'b1;
            if (r_wait == WAIT_LIM - 1'b1)
              timeout_o <= 1'b1;
          end
        end
        RESP: begin
          if_valid_o <= 1'b0;
          dm_valid_o <= 1'b0;
          r_state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural memory.
// Directed scenarios first, then randomized concurrent requesters.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 64;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic [31:0] if_rdata_o;
  logic        if_valid_o;
  logic        if_stall_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [31:0] dm_addr_i;
  logic [31:0] dm_wdata_i;
  logic [31:0] dm_rdata_o;
  logic        dm_valid_o;
  logic        dm_stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        timeout_o;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32),
    .STARVE_MAX(STARVE), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i),
    .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Initial memory image: any address not written reads this pattern
  function automatic logic [31:0] fimg(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // ---------------- behavioural memory ----------------
  logic [31:0] mem [logic [31:0]];
  int          mem_wait = 0;
  logic        ack_r = 1'b0;
  logic [31:0] rd_r = '0;
  logic        force_ack = 1'b0;
  logic [31:0] fake_rd = '0;

  assign mem_ack_i   = ack_r | force_ack;
  assign mem_rdata_i = force_ack ? fake_rd : rd_r;

  initial begin
    int  cnt;
    int  tgt;
    bit  active;
    cnt = 0; tgt = 0; active = 0;
    forever begin
      @(posedge clk_i);
      #1;
      ack_r = 1'b0;
      if (mem_req_o) begin
        if (!active) begin
          active = 1;
          cnt = 0;
          tgt = $urandom_range(0, 3);
        end
        if (cnt >= ((mem_wait < 0) ? tgt : mem_wait)) begin
          ack_r = 1'b1;
          if (mem_we_o) begin
            mem[mem_addr_o] = mem_wdata_o;
            rd_r = $urandom;
          end else begin
            rd_r = mem.exists(mem_addr_o) ? mem[mem_addr_o]
                                          : fimg(mem_addr_o);
          end
          active = 0;
        end else begin
          cnt++;
        end
      end else begin
        active = 0;
      end
    end
  end

  // ---------------- reference + scoreboard ----------------
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] last_ld = '0;

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : fimg(a);
  endfunction

  bit          arb_en = 0;
  int          scnt = 0;
  logic        p_if = 0, p_dm = 0, p_we = 0, p_mreq = 0;
  logic        p_ifv = 0, p_dmv = 0;
  logic [31:0] p_ifa = '0, p_dma = '0, p_wd = '0;

  always @(negedge clk_i) begin
    logic [31:0] e;
    bit          is_dm;
    bit          exp_dm;
    if (!rst_i) begin
      chk("if_stall", if_stall_o, if_req_i & ~if_valid_o);
      chk("dm_stall", dm_stall_o, dm_req_i & ~dm_valid_o);
      if (if_valid_o) begin
        chk("if_pulse_len", p_ifv, 0);
        if (if_q.size() == 0) chk("if_unexpected", if_valid_o, 0);
        else begin
          e = if_q.pop_front();
          chk("if_rdata", if_rdata_o, e);
        end
      end
      if (dm_valid_o) begin
        chk("dm_pulse_len", p_dmv, 0);
        if (dm_q.size() == 0) chk("dm_unexpected", dm_valid_o, 0);
        else begin
          e = dm_q.pop_front();
          chk("dm_rdata", dm_rdata_o, e);
        end
      end
      if (arb_en && mem_req_o && !p_mreq) begin
        is_dm  = mem_addr_o[16];
        exp_dm = p_dm && !(p_if && scnt == STARVE);
        chk("gnt_req", p_if | p_dm, 1);
        chk("gnt_sel", is_dm, exp_dm);
        if (is_dm) begin
          chk("gnt_dm_addr", mem_addr_o, p_dma);
          chk("gnt_dm_we", mem_we_o, p_we);
          if (p_we) chk("gnt_dm_wdata", mem_wdata_o, p_wd);
          if (p_if && scnt < STARVE) scnt++;
        end else begin
          chk("gnt_if_addr", mem_addr_o, p_ifa);
          chk("gnt_if_we", mem_we_o, 0);
          scnt = 0;
        end
      end
    end
    p_if = if_req_i; p_dm = dm_req_i; p_we = dm_we_i;
    p_ifa = if_addr_i; p_dma = dm_addr_i; p_wd = dm_wdata_i;
    p_mreq = mem_req_o; p_ifv = if_valid_o; p_dmv = dm_valid_o;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic neg();
    @(negedge clk_i);
  endtask

  // ---------------- random requesters ----------------
  task automatic if_proc(input int n);
    logic [31:0] a;
    bit          got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 32'h0000_1000 | ($urandom & 32'h0000_0FFC);
      if_q.push_back(fimg(a));
      if_addr_i = a;
      if_req_i  = 1'b1;
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        tick();
        if (if_valid_o) got = 1;
      end
      chk("if_done", got, 1);
      if_req_i = 1'b0;
    end
  endtask

  task automatic dm_proc(input int n);
    logic [31:0] a;
    logic [31:0] e;
    bit          got;
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      a = 32'h0001_0000 | ($urandom & 32'h0000_00FC);
      dm_addr_i = a;
      dm_we_i   = $urandom_range(0, 1);
      if (dm_we_i) begin
        dm_wdata_i = $urandom;
        ref_mem[a] = dm_wdata_i;
        dm_q.push_back(last_ld);
      end else begin
        e = ref_rd(a);
        last_ld = e;
        dm_q.push_back(e);
      end
      dm_req_i = 1'b1;
      got = 0;
      for (int c = 0; c < 300 && !got; c++) begin
        tick();
        if (dm_valid_o) got = 1;
      end
      chk("dm_done", got, 1);
      dm_req_i = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [31:0] seq_exp [6];
    logic [31:0] seq_got [6];
    int          ng;
    bit          pm;
    int          busy;
    bit          got;

    rst_i = 1'b1;
    if_req_i = 0; if_addr_i = '0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0; dm_wdata_i = '0;
    mem[32'h10] = 32'h0062_8293;
    repeat (3) tick();
    neg();
    chk("rst_mem_req", mem_req_o, 0);
    chk("rst_if_valid", if_valid_o, 0);
    chk("rst_dm_valid", dm_valid_o, 0);
    chk("rst_timeout", timeout_o, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_if_rdata", if_rdata_o, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);

    // Zero-wait fetch latency
    mem_wait = 0;
    tick();
    rst_i = 1'b0;
    if_req_i = 1'b1; if_addr_i = 32'h10;
    if_q.push_back(32'h0062_8293);
    neg();
    chk("t1_c0_stall", if_stall_o, 1);
    chk("t1_c0_req", mem_req_o, 0);
    tick(); neg();
    chk("t1_c1_req", mem_req_o, 1);
    chk("t1_c1_addr", mem_addr_o, 32'h10);
    chk("t1_c1_valid", if_valid_o, 0);
    tick(); neg();
    chk("t1_c2_req", mem_req_o, 0);
    chk("t1_c2_valid", if_valid_o, 1);
    chk("t1_c2_rdata", if_rdata_o, 32'h0062_8293);
    tick();
    if_req_i = 1'b0;
    neg();
    chk("t1_c3_valid", if_valid_o, 0);

    // Store beats a simultaneous fetch, 2 wait cycles
    mem_wait = 2;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h20;
    dm_req_i = 1'b1; dm_we_i = 1'b1;
    dm_addr_i = 32'h40; dm_wdata_i = 32'hDEAD_BEEF;
    ref_mem[32'h40] = 32'hDEAD_BEEF;
    dm_q.push_back(last_ld);
    if_q.push_back(fimg(32'h20));
    neg();
    for (int c = 1; c <= 3; c++) begin
      tick(); neg();
      chk("t2_req", mem_req_o, 1);
      chk("t2_we", mem_we_o, 1);
      chk("t2_addr", mem_addr_o, 32'h40);
      chk("t2_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    end
    tick(); neg();
    chk("t2_dm_valid", dm_valid_o, 1);
    chk("t2_if_valid", if_valid_o, 0);
    mem_wait = 0;
    tick();
    dm_req_i = 1'b0;
    neg();
    chk("t2_c5_req", mem_req_o, 0);
    tick(); neg();
    chk("t2_if_gnt", mem_req_o, 1);
    chk("t2_if_we", mem_we_o, 0);
    chk("t2_if_addr", mem_addr_o, 32'h20);
    tick(); neg();
    chk("t2_if_valid2", if_valid_o, 1);
    tick();
    if_req_i = 1'b0;
    neg();

    // Starvation: D D D D I D with both held high
    seq_exp = '{32'h80, 32'h80, 32'h80, 32'h80, 32'h50, 32'h80};
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h50;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h80;
    ng = 0;
    pm = 0;
    neg();
    for (int c = 0; c < 60 && ng < 6; c++) begin
      tick(); neg();
      if (mem_req_o && !pm) begin
        seq_got[ng] = mem_addr_o;
        if (mem_addr_o == 32'h80) begin
          last_ld = ref_rd(32'h80);
          dm_q.push_back(last_ld);
        end else begin
          if_q.push_back(fimg(32'h50));
        end
        ng++;
      end
      pm = mem_req_o;
    end
    chk("t3_ngrants", ng, 6);
    for (int i = 0; i < ng; i++)
      chk("t3_seq", seq_got[i], seq_exp[i]);
    tick();
    if_req_i = 1'b0;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      neg();
      if (dm_valid_o) got = 1;
      tick();
    end
    chk("t3_dm_done", got, 1);
    dm_req_i = 1'b0;
    neg();

    // Memory stalls past the timeout, then completes late
    mem_wait = 1000;
    tick();
    if_req_i = 1'b1; if_addr_i = 32'h30;
    if_q.push_back(fimg(32'h30));
    busy = 0;
    for (int c = 0; c < 100 && busy < 70; c++) begin
      neg();
      if (mem_req_o) busy++;
      if (busy == 60) chk("t4_tmo_early", timeout_o, 0);
      if (busy < 70) tick();
    end
    chk("t4_tmo_set", timeout_o, 1);
    chk("t4_req_held", mem_req_o, 1);
    chk("t4_addr_held", mem_addr_o, 32'h30);
    mem_wait = 0;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick(); neg();
      if (if_valid_o) got = 1;
    end
    chk("t4_late_done", got, 1);
    tick();
    if_req_i = 1'b0;
    repeat (3) tick();
    neg();
    chk("t4_tmo_sticky", timeout_o, 1);

    // Reset in the second wait cycle of a load, late ack after
    mem_wait = 1000;
    tick();
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h44;
    neg();
    tick(); neg();
    chk("t5_req", mem_req_o, 1);
    tick();
    rst_i = 1'b1; dm_req_i = 1'b0;
    neg();
    tick();
    rst_i = 1'b0;
    fake_rd = 32'hCAFE_F00D;
    force_ack = 1'b1;
    last_ld = '0;
    neg();
    chk("t5_req_drop", mem_req_o, 0);
    chk("t5_no_valid", dm_valid_o, 0);
    chk("t5_rdata", dm_rdata_o, 0);
    chk("t5_tmo_clr", timeout_o, 0);
    tick();
    force_ack = 1'b0;
    neg();
    chk("t5_no_valid2", dm_valid_o, 0);
    chk("t5_req2", mem_req_o, 0);

    // Spurious ack while idle
    tick();
    fake_rd = 32'h1234_5678;
    force_ack = 1'b1;
    neg();
    tick();
    force_ack = 1'b0;
    neg();
    chk("t6_if_valid", if_valid_o, 0);
    chk("t6_dm_valid", dm_valid_o, 0);
    chk("t6_if_rdata", if_rdata_o, 0);
    chk("t6_dm_rdata", dm_rdata_o, 0);
    chk("t6_mem_req", mem_req_o, 0);
    chk("t6_mem_addr", mem_addr_o, 0);
    chk("t6_tmo", timeout_o, 0);

    // Randomized concurrent traffic
    mem_wait = -1;
    scnt = 0;
    arb_en = 1;
    fork
      if_proc(40);
      dm_proc(40);
    join
    repeat (5) tick();
    neg();
    chk("if_q_empty", if_q.size(), 0);
    chk("dm_q_empty", dm_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported backing memory between the IF-stage instruction fetch and the MEM-stage data access of the 5-stage pipelined CPU.
- Sequences each access with a req/ack handshake toward memory, which may take a variable number of wait cycles.
- Returns read data to the winning requester and drives per-requester stall outputs into the PC/IF_ID and EX_MEM/MEM_WB write enables.
- Data accesses have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive data grants made while a fetch waits, after which fetch wins once.
- TIMEOUT_CYC, 64, wait cycles in a BUSY state without mem_ack_i before timeout_o sets.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- if_req_i  in  1  fetch request; held with if_addr_i stable until if_valid_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_valid_o  out  1  one-cycle pulse; if_rdata_o valid.
- if_stall_o  out  1  if_req_i & ~if_valid_o.
- dm_req_i  in  1  data request; held with addr/we/wdata stable until dm_valid_o.
- dm_we_i  in  1  1 = store, 0 = load.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  store data.
- dm_rdata_o  out  DATA_W  load data.
- dm_valid_o  out  1  one-cycle completion pulse (load or store).
- dm_stall_o  out  1  dm_req_i & ~dm_valid_o.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  memory write enable, registered.
- mem_addr_o  out  ADDR_W  memory address, registered.
- mem_wdata_o  out  DATA_W  memory write data, registered.
- mem_ack_i  in  1  memory completion; mem_rdata_i valid in the same cycle.
- mem_rdata_i  in  DATA_W  memory read data.
- timeout_o  out  1  sticky timeout flag.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (rst_i). All state updates on the rising edge.
- Reset values:
  - state = IDLE.
  - mem_req_o, mem_we_o, if_valid_o, dm_valid_o, timeout_o = 0.
  - mem_addr_o, mem_wdata_o, if_rdata_o, dm_rdata_o = 0.
  - Starvation and wait counters = 0.
- FSM states: IDLE, BUSY_IF, BUSY_DM, RESP.
- IDLE arbitration, applied at each edge:
  - Grant DM if dm_req_i and not (if_req_i and starve_cnt == STARVE_MAX).
  - Otherwise grant IF if if_req_i.
  - Otherwise stay in IDLE.
- On a grant:
  - Register mem_req_o = 1, mem_addr_o, mem_we_o (dm_we_i for DM, 0 for IF) and mem_wdata_o (dm_wdata_i for DM, don't-care for IF).
  - Move to BUSY_DM or BUSY_IF.
- Starvation counter:
  - Increments on a DM grant while if_req_i = 1, saturating at STARVE_MAX.
  - Clears on any IF grant.
  - Left unchanged on a DM grant with if_req_i = 0.
- BUSY_x:
  - mem_* outputs are held stable while mem_ack_i = 0; the wait counter increments.
  - On mem_ack_i = 1: mem_req_o drops to 0, the wait counter clears and the state moves to RESP.
  - On an IF ack, if_rdata_o <= mem_rdata_i and if_valid_o <= 1.
  - On a DM load ack, dm_rdata_o <= mem_rdata_i and dm_valid_o <= 1.
  - On a DM store ack, dm_valid_o <= 1 and dm_rdata_o holds its previous value.
- RESP:
  - Lasts exactly one cycle with the valid pulse high, and makes no grant.
  - Returns to IDLE with the valid output cleared.
  - This guards against re-granting a request the requester has not yet dropped.
- Latency with a zero-wait memory (ack during the first cycle mem_req_o is high):
  - Request sampled at edge 0.
  - mem_req_o high in cycle 1.
  - Valid pulse in cycle 2.
  - Next grant no earlier than edge 3. Peak rate is 1 access per 3 cycles; each memory wait cycle adds 1.
- Timeout:
  - When the wait counter reaches TIMEOUT_CYC, timeout_o <= 1 and stays set until rst_i.
  - The access is not aborted; the block keeps waiting for mem_ack_i.
- mem_ack_i in IDLE or RESP is ignored.
- Address and data widths are passed through unmodified; no alignment checks.
- Reset mid-access: the next edge forces IDLE with mem_req_o = 0. A late ack after reset is ignored, and no valid pulse is produced for the aborted access.

Decomposition:
- mem_arb_pkg:
  - state enum {IDLE, BUSY_IF, BUSY_DM, RESP}.
  - Grant encoding constants GNT_NONE/GNT_IF/GNT_DM.
  - Default ADDR_W/DATA_W constants.
- No sub-module: the FSM, both counters and the output registers fit in one module.

Test Plan:
- Reset, then if_req_i = 1, if_addr_i = 0x0000_0010, memory acks in the first cycle with 0x0062_8293 -> mem_req_o high in cycle 1 only; if_valid_o pulse in cycle 2 with if_rdata_o = 0x0062_8293; if_stall_o = 1 in cycles 0–1.
- if_req_i and dm_req_i both high, dm_we_i = 1, dm_addr_i = 0x40, dm_wdata_i = 0xDEAD_BEEF, 2 wait cycles -> DM granted first; mem_we_o = 1 and mem_wdata_o = 0xDEAD_BEEF stable through the waits; dm_valid_o pulses; IF is granted next.
- dm_req_i held high continuously with if_req_i high, STARVE_MAX = 4 -> grants DM, DM, DM, DM, then IF, then DM again.
- Memory never acks, TIMEOUT_CYC = 64 -> timeout_o rises after 64 BUSY cycles; mem_req_o stays 1; a later ack completes normally and timeout_o remains 1.
- rst_i asserted in the second wait cycle of a DM load, ack arrives the cycle after -> mem_req_o = 0, no dm_valid_o, state IDLE, dm_rdata_o = 0.
- Spurious mem_ack_i = 1 in IDLE with no requests -> no valid pulse; all outputs unchanged.
